ntt_coeff_obi_bank: RTL and testbench

// - Coefficient memory bank just downstream of the external bus, inside the NTT/INTT accelerator top.
// - Serves one OBI slave port (CPU/DMA loads and unloads polynomials) and one accelerator-side datapath port.
// - Packs two 12-bit Kyber coefficients per 32-bit word and reduces written values mod Q.
// - An ownership FSM hands the bank between the bus and the NTT datapath.

---
 rtl/ntt_coeff_pkg.sv | 30 +++
 rtl/obi_pkg.sv | 18 +
 rtl/ntt_coeff_sram.sv | 33 +++
 rtl/ntt_coeff_obi_bank.sv | 133 +++++++++++++
 tb/tb_ntt_coeff_obi_bank.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ntt_coeff_pkg.sv
// Kyber coefficient constants, bank ownership states and lane packing helpers.
package ntt_coeff_pkg;

  localparam int KYBER_Q         = 3329;
  localparam int COEFF_W         = 12;
  localparam int COEFFS_PER_POLY = 256;
  localparam int WORD_W          = 2 * COEFF_W;

  typedef enum logic [1:0] {
    ST_BUS   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_ACC   = 2'd2
  } own_state_e;

  // A 12-bit value never reaches 2Q, so one conditional subtraction reduces it.
  function automatic logic [COEFF_W-1:0] red_coeff(input logic [COEFF_W-1:0] x);
    return (x >= COEFF_W'(KYBER_Q)) ? x - COEFF_W'(KYBER_Q) : x;
  endfunction

  // Stored word {hi, lo} -> bus word {4'b0, hi, 4'b0, lo}.
  function automatic logic [31:0] pack_bus(input logic [WORD_W-1:0] w);
    return {4'b0, w[WORD_W-1:COEFF_W], 4'b0, w[COEFF_W-1:0]};
  endfunction

  // Bus word -> reduced stored word; the 4-bit pads of each halfword are dropped.
  function automatic logic [WORD_W-1:0] unpack_bus(input logic [31:0] d);
    return {red_coeff(d[27:16]), red_coeff(d[11:0])};
  endfunction

endpackage

// File: rtl/obi_pkg.sv
// OBI slave request/response bundles shared by bus-attached blocks.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/ntt_coeff_sram.sv
// Single-port synchronous coefficient RAM, two 12-bit lanes per word, 1-cycle read.
module ntt_coeff_sram
  import ntt_coeff_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [1:0]        lane_en_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  // Lane-masked write; the read register only updates on a read access.
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      if (lane_en_i[0]) mem_q[addr_i][COEFF_W-1:0]      <= wdata_i[COEFF_W-1:0];
      if (lane_en_i[1]) mem_q[addr_i][WORD_W-1:COEFF_W] <= wdata_i[WORD_W-1:COEFF_W];
    end
    if (en_i && !we_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ntt_coeff_obi_bank.sv
// Coefficient bank shared between an OBI slave port and the NTT datapath,
// with an ownership FSM that drains the bus before handing over the RAM.
module ntt_coeff_obi_bank
  import obi_pkg::*;
  import ntt_coeff_pkg::*;
#(
  parameter int          NUM_POLY  = 2,
  parameter logic [31:0] ADDR_BASE = 32'h0,
  localparam int         DEPTH     = NUM_POLY * COEFFS_PER_POLY / 2,
  localparam int         AW        = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  obi_req_t          slave_req_i,
  output obi_resp_t         slave_resp_o,
  input  logic              acc_own_req_i,
  input  logic              acc_release_i,
  output logic              acc_grant_o,
  input  logic              acc_en_i,
  input  logic              acc_we_i,
  input  logic [AW-1:0]     acc_addr_i,
  input  logic [WORD_W-1:0] acc_wdata_i,
  output logic [WORD_W-1:0] acc_rdata_o,
  output logic              oor_o
);

  own_state_e        state_q, state_d;
  logic              acc_grant_q, acc_grant_d;
  logic              rvalid_q, rvalid_d;
  logic              rd_q, rd_d;           // granted in-range bus read awaiting data
  logic              acc_rd_q, acc_rd_d;   // datapath read awaiting data
  logic [WORD_W-1:0] acc_hold_q, acc_hold_d;

  logic [31:0]       offset;
  logic [29:0]       word_idx;
  logic              in_range;
  logic              gnt;

  logic              ram_en, ram_we;
  logic [1:0]        ram_lane_en;
  logic [AW-1:0]     ram_addr;
  logic [WORD_W-1:0] ram_wdata, ram_rdata;

  logic              unused_bits;

  assign offset   = slave_req_i.addr - ADDR_BASE;
  assign word_idx = offset[31:2];
  assign in_range = (word_idx < 30'(DEPTH));
  // An ownership request in the same cycle as a bus request wins the tie.
  assign gnt      = slave_req_i.req && (state_q == ST_BUS) && !acc_own_req_i;

  assign unused_bits = ^{offset[1:0], slave_req_i.wdata[31:28], slave_req_i.wdata[15:12]};

  // RAM port mux: the datapath drives the RAM only while it owns the bank.
  always_comb begin
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_lane_en = 2'b00;
    ram_addr    = '0;
    ram_wdata   = '0;
    if (state_q == ST_ACC) begin
      ram_en      = acc_en_i;
      ram_we      = acc_we_i;
      ram_lane_en = 2'b11;
      ram_addr    = acc_addr_i;
      ram_wdata   = acc_wdata_i;
    end else begin
      ram_en      = gnt && in_range;
      ram_we      = slave_req_i.we;
      ram_lane_en = {|slave_req_i.be[3:2], |slave_req_i.be[1:0]};
      ram_addr    = word_idx[AW-1:0];
      ram_wdata   = unpack_bus(slave_req_i.wdata);
    end
  end

  ntt_coeff_sram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sram (
    .clk_i     (clk_i),
    .en_i      (ram_en),
    .we_i      (ram_we),
    .lane_en_i (ram_lane_en),
    .addr_i    (ram_addr),
    .wdata_i   (ram_wdata),
    .rdata_o   (ram_rdata)
  );

  // Datapath read data tracks the RAM on the cycle after a read, else holds.
  assign acc_rdata_o = acc_rd_q ? ram_rdata : acc_hold_q;

  // Next-state for ownership FSM and the response/pending tracking flops.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BUS:   if (acc_own_req_i) state_d = ST_DRAIN;
      ST_DRAIN: if (!rvalid_q)     state_d = ST_ACC;
      ST_ACC:   if (acc_release_i) state_d = ST_BUS;
      default:                     state_d = ST_BUS;
    endcase
    acc_grant_d = (state_d == ST_ACC);
    rvalid_d    = gnt;
    rd_d        = gnt && !slave_req_i.we && in_range;
    acc_rd_d    = (state_q == ST_ACC) && acc_en_i && !acc_we_i;
    acc_hold_d  = acc_rdata_o;
  end

  // Ownership FSM with registered grant and OBI response state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_BUS;
      acc_grant_q <= 1'b0;
      rvalid_q    <= 1'b0;
      rd_q        <= 1'b0;
      acc_rd_q    <= 1'b0;
      acc_hold_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_grant_q <= acc_grant_d;
      rvalid_q    <= rvalid_d;
      rd_q        <= rd_d;
      acc_rd_q    <= acc_rd_d;
      acc_hold_q  <= acc_hold_d;
    end
  end

  assign acc_grant_o         = acc_grant_q;
  assign oor_o               = gnt && !in_range;
  assign slave_resp_o.gnt    = gnt;
  assign slave_resp_o.rvalid = rvalid_q;
  assign slave_resp_o.rdata  = rd_q ? pack_bus(ram_rdata) : 32'h0;

endmodule

// File: tb/tb_ntt_coeff_obi_bank.sv
// Scoreboard bench for ntt_coeff_obi_bank: bus traffic, ownership hand-over, reset.
module tb_ntt_coeff_obi_bank;
  import obi_pkg::*;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  obi_req_t    req_s;
  obi_resp_t   resp_s;
  logic        acc_own_req, acc_release, acc_grant, acc_en, acc_we, oor;
  logic [7:0]  acc_addr;
  logic [23:0] acc_wdata, acc_rdata;

  always #5 clk = ~clk;

  ntt_coeff_obi_bank #(
    .NUM_POLY  (2),
    .ADDR_BASE (32'h0)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .slave_req_i   (req_s),
    .slave_resp_o  (resp_s),
    .acc_own_req_i (acc_own_req),
    .acc_release_i (acc_release),
    .acc_grant_o   (acc_grant),
    .acc_en_i      (acc_en),
    .acc_we_i      (acc_we),
    .acc_addr_i    (acc_addr),
    .acc_wdata_i   (acc_wdata),
    .acc_rdata_o   (acc_rdata),
    .oor_o         (oor)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  typedef struct {
    bit          cmp;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t sb[$];

  // Reference model for the randomised region of the bank.
  logic [11:0] m_lo [DEPTH];
  logic [11:0] m_hi [DEPTH];

  function automatic logic [11:0] ref_red(input logic [11:0] x);
    return (x >= 12'd3329) ? x - 12'd3329 : x;
  endfunction

  // Response monitor: rvalid one cycle after gnt, rdata from the scoreboard.
  logic gnt_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      gnt_prev = 1'b0;
    end else begin
      check_val("rvalid_lat", {31'b0, resp_s.rvalid}, {31'b0, gnt_prev});
      if (resp_s.rvalid) begin
        if (sb.size() == 0) begin
          check_val("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          if (e.cmp) check_val(e.tag, resp_s.rdata, e.val);
        end
      end else begin
        check_val("rdata_idle", resp_s.rdata, 32'h0);
      end
      gnt_prev = resp_s.gnt;
    end
  end

  // Present one request for one cycle; req stays high until the next call or bus_idle.
  task automatic bus_issue(input logic we, input logic [3:0] be, input logic [31:0] addr,
                           input logic [31:0] wdata, input bit cmp, input logic [31:0] exp_rd,
                           input logic exp_oor, input string tag);
    req_s.req   = 1'b1;
    req_s.we    = we;
    req_s.be    = be;
    req_s.addr  = addr;
    req_s.wdata = wdata;
    @(negedge clk);
    check_val({tag, "_gnt"}, {31'b0, resp_s.gnt}, 32'd1);
    check_val({tag, "_oor"}, {31'b0, oor}, {31'b0, exp_oor});
    if (resp_s.gnt) sb.push_back('{cmp, exp_rd, tag});
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle(input int n);
    req_s.req = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input string tag);
    bit got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      @(negedge clk);
      check_val({tag, "_gnt_blocked"}, {31'b0, resp_s.gnt}, 32'd0);
      if (acc_grant) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check_val({tag, "_acc_grant"}, {31'b0, got}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_gnt"},       {31'b0, resp_s.gnt},    32'd0);
    check_val({tag, "_rvalid"},    {31'b0, resp_s.rvalid}, 32'd0);
    check_val({tag, "_rdata"},     resp_s.rdata,           32'd0);
    check_val({tag, "_acc_grant"}, {31'b0, acc_grant},     32'd0);
    check_val({tag, "_acc_rdata"}, {8'b0, acc_rdata},      32'd0);
    check_val({tag, "_oor"},       {31'b0, oor},           32'd0);
  endtask

  initial begin
    logic [31:0] wd;
    logic [3:0]  be;
    int          w;

    req_s       = '0;
    acc_own_req = 1'b0;
    acc_release = 1'b0;
    acc_en      = 1'b0;
    acc_we      = 1'b0;
    acc_addr    = '0;
    acc_wdata   = '0;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic packing, reduction and partial-lane writes, back-to-back.
    bus_issue(1'b1, 4'hF, 32'h0, 32'h0123_0456, 1'b0, 32'h0,         1'b0, "wr0");
    bus_issue(1'b0, 4'hF, 32'h0, 32'h0,         1'b1, 32'h0123_0456, 1'b0, "rd0");
    bus_issue(1'b1, 4'hF, 32'h4, 32'h0FFF_0D01, 1'b0, 32'h0,         1'b0, "wr1_red");
    bus_issue(1'b0, 4'hF, 32'h4, 32'h0,         1'b1, 32'h02FE_0000, 1'b0, "rd1_red");
    bus_issue(1'b1, 4'h3, 32'h0, 32'hAAAA_BBBB, 1'b0, 32'h0,         1'b0, "wr0_lo");
    bus_issue(1'b0, 4'hF, 32'h0, 32'h0,         1'b1, 32'h0123_0BBB, 1'b0, "rd0_lo");
    bus_issue(1'b1, 4'hC, 32'h4, 32'h0D05_FFFF, 1'b0, 32'h0,         1'b0, "wr1_hi");
    bus_issue(1'b0, 4'hF, 32'h4, 32'h0,         1'b1, 32'h0004_0000, 1'b0, "rd1_hi");
    bus_idle(1);

    // Out-of-range word DEPTH: normal handshake, zero data, dropped write.
    bus_issue(1'b0, 4'hF, 32'h400, 32'h0,         1'b1, 32'h0,         1'b1, "rd_oor");
    bus_issue(1'b1, 4'hF, 32'h400, 32'h0777_0777, 1'b0, 32'h0,         1'b1, "wr_oor");
    bus_issue(1'b0, 4'hF, 32'h0,   32'h0,         1'b1, 32'h0123_0BBB, 1'b0, "rd0_after_oor");
    bus_idle(1);

    // Randomised traffic over words 8..15 against the reference model.
    for (int i = 8; i < 16; i++) begin
      wd = $urandom;
      m_lo[i] = ref_red(wd[11:0]);
      m_hi[i] = ref_red(wd[27:16]);
      bus_issue(1'b1, 4'hF, 32'(i * 4), wd, 1'b0, 32'h0, 1'b0, "rnd_init");
    end
    for (int i = 0; i < 24; i++) begin
      w  = 8 + int'($urandom_range(0, 7));
      wd = $urandom;
      be = 4'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        if (be[1:0] != 2'b00) m_lo[w] = ref_red(wd[11:0]);
        if (be[3:2] != 2'b00) m_hi[w] = ref_red(wd[27:16]);
        bus_issue(1'b1, be, 32'(w * 4), wd, 1'b0, 32'h0, 1'b0, "rnd_wr");
      end else begin
        bus_issue(1'b0, be, 32'(w * 4), 32'h0, 1'b1, {4'b0, m_hi[w], 4'b0, m_lo[w]}, 1'b0, "rnd_rd");
      end
    end
    bus_idle(1);

    // Ownership request collides with a held bus request.
    bus_issue(1'b0, 4'hF, 32'h0, 32'h0, 1'b1, 32'h0123_0BBB, 1'b0, "rd_before_own");
    req_s.addr  = 32'h4;
    acc_own_req = 1'b1;
    @(negedge clk);
    check_val("tie_gnt",    {31'b0, resp_s.gnt},    32'd0);
    check_val("tie_rvalid", {31'b0, resp_s.rvalid}, 32'd1);
    check_val("tie_grant",  {31'b0, acc_grant},     32'd0);
    @(posedge clk);
    #1;
    wait_grant("own1");
    req_s.req = 1'b0;

    // Datapath accesses while owning the bank.
    acc_en = 1'b1; acc_we = 1'b0; acc_addr = 8'd0;
    @(posedge clk);
    #1;
    acc_we = 1'b1; acc_addr = 8'd3; acc_wdata = 24'h005006;
    @(negedge clk);
    check_val("acc_rd0", {8'b0, acc_rdata}, 32'h0012_3BBB);
    @(posedge clk);
    #1;
    acc_we = 1'b0;
    @(posedge clk);
    #1;
    acc_en = 1'b0;
    @(negedge clk);
    check_val("acc_rd3", {8'b0, acc_rdata}, 32'h0000_5006);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_val("acc_hold",  {8'b0, acc_rdata}, 32'h0000_5006);
    check_val("acc_owned", {31'b0, acc_grant}, 32'd1);
    @(posedge clk);
    #1;

    // Release with a bus request waiting: gnt resumes one cycle later.
    req_s.req = 1'b1; req_s.we = 1'b0; req_s.addr = 32'hC;
    acc_release = 1'b1;
    acc_own_req = 1'b0;
    @(negedge clk);
    check_val("release_cycle_gnt", {31'b0, resp_s.gnt}, 32'd0);
    @(posedge clk);
    #1;
    acc_release = 1'b0;
    bus_issue(1'b0, 4'hF, 32'hC, 32'h0, 1'b1, 32'h0005_0006, 1'b0, "rd3_resume");
    bus_idle(1);
    check_val("grant_dropped", {31'b0, acc_grant}, 32'd0);

    // Datapath enable outside ownership is ignored; stray release in BUS too.
    acc_en = 1'b1; acc_we = 1'b1; acc_addr = 8'd3; acc_wdata = 24'hFFFFFF;
    @(posedge clk);
    #1;
    acc_we = 1'b0; acc_addr = 8'd0;
    @(posedge clk);
    #1;
    acc_en = 1'b0;
    @(negedge clk);
    check_val("acc_ign_hold", {8'b0, acc_rdata}, 32'h0000_5006);
    @(posedge clk);
    #1;
    acc_release = 1'b1;
    bus_issue(1'b0, 4'hF, 32'hC, 32'h0, 1'b1, 32'h0005_0006, 1'b0, "rd3_stray_rel");
    acc_release = 1'b0;
    bus_idle(1);

    // Reset while owning the bank with a datapath read in flight.
    acc_own_req = 1'b1;
    wait_grant("own2");
    acc_en = 1'b1; acc_we = 1'b0; acc_addr = 8'd3;
    @(posedge clk);
    #2;
    rst_n       = 1'b0;
    acc_own_req = 1'b0;
    acc_en      = 1'b0;
    #1;
    check_all_zero("mid_reset");
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus_issue(1'b0, 4'hF, 32'hC, 32'h0, 1'b1, 32'h0005_0006, 1'b0, "rd3_after_rst");
    bus_issue(1'b0, 4'hF, 32'h0, 32'h0, 1'b1, 32'h0123_0BBB, 1'b0, "rd0_after_rst");
    bus_idle(3);
    check_val("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
